tick_counter: RTL and testbench

Decimal event counter that sits directly downstream of `clkdiv`. It takes the slow `clk_div` square wave and samples it in the fast `clk` domain. Each rising edge of `clk_div` becomes a single-cycle tick, and each tick advances a DIGITS-wide packed-BCD up/down counter. The block provides synchronous load, enable and a terminal-count pulse for display or cascade logic.

---
 rtl/tick_counter.sv | 66 ++++++
 tb/tb_tick_counter.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/tick_counter.sv
// tick_counter: clk_div rising edges, synchronised into clk, step a packed-BCD up/down counter.
// Define TICK_COUNTER_SAT_EN to saturate at all-nines/zero instead of wrapping.
module tick_counter #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clk_div,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   count,
  output logic                  tc,
  output logic                  tick
);
  localparam int W = 4 * DIGITS;
  logic s1_q, s2_q, s3_q, tc_q, tc_d, cy, bw, wrap, step;
  logic [3:0] dg;
  logic [W-1:0] count_q, count_d, inc, dec, ld, nxt;
  // cy/bw end as the all-nines/all-zeros flags once the ripple finishes
  always_comb begin
    cy = 1'b1;
    bw = 1'b1;
    inc = '0;
    dec = '0;
    ld = '0;
    dg = '0;
    for (int i = 0; i < DIGITS; i++) begin
      dg = count_q[4*i +: 4];
      inc[4*i +: 4] = !cy ? dg : (dg == 4'd9) ? 4'd0 : dg + 4'd1;
      dec[4*i +: 4] = !bw ? dg : (dg == 4'd0) ? 4'd9 : dg - 4'd1;
      cy = cy & (dg == 4'd9);
      bw = bw & (dg == 4'd0);
      ld[4*i +: 4] = (load_val[4*i +: 4] > 4'd9) ? 4'd9 : load_val[4*i +: 4];
    end
  end
  assign tick = s2_q & ~s3_q;
  assign wrap = up ? cy : bw;
  assign step = tick & en & ~load;
`ifdef TICK_COUNTER_SAT_EN
  assign nxt = wrap ? count_q : up ? inc : dec;
`else
  assign nxt = up ? inc : dec;
`endif
  assign count_d = load ? ld : step ? nxt : count_q;
  assign tc_d = step & wrap;
  // sync flops reset high so a clk_div already high at release is not an edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
      s3_q <= 1'b1;
      count_q <= '0;
      tc_q <= 1'b0;
    end else begin
      s1_q <= clk_div;
      s2_q <= s1_q;
      s3_q <= s2_q;
      count_q <= count_d;
      tc_q <= tc_d;
    end
  end
  assign count = count_q;
  assign tc = tc_q;
endmodule

// File: tb/tb_tick_counter.sv
// tb_tick_counter: directed plus randomised ticks against an integer-valued decimal counter model.
module tb_tick_counter;
  localparam int D = 4;
  localparam int M = 10000;
  logic clk = 1'b0, rst = 1'b0, clk_div = 1'b1, en = 1'b0, up = 1'b1, load = 1'b0;
  logic [15:0] load_val = '0;
  logic [15:0] count;
  logic tc, tick;
  int errors = 0, checks = 0, cnt = 0;
  bit etc = 1'b0;

  tick_counter #(.DIGITS(D)) dut (
    .clk(clk), .rst(rst), .clk_div(clk_div), .en(en), .up(up), .load(load),
    .load_val(load_val), .count(count), .tc(tc), .tick(tick)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] bcd(input int v);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic int san(input logic [15:0] x);
    int r, p, n;
    r = 0;
    p = 1;
    for (int i = 0; i < D; i++) begin
      n = int'(x[4*i +: 4]);
      r += ((n > 9) ? 9 : n) * p;
      p *= 10;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clk1;
    @(posedge clk);
    #1;
  endtask

  task automatic model_step(input bit ld, input logic [15:0] lv);
    bit wrap;
    if (ld) begin
      cnt = san(lv);
      etc = 1'b0;
    end else if (en) begin
      wrap = up ? (cnt == M - 1) : (cnt == 0);
      etc = wrap;
`ifdef TICK_COUNTER_SAT_EN
      if (!wrap) cnt = up ? cnt + 1 : cnt - 1;
`else
      cnt = up ? (cnt + 1) % M : (cnt + M - 1) % M;
`endif
    end else begin
      etc = 1'b0;
    end
  endtask

  task automatic do_load(input logic [15:0] lv);
    load = 1'b1;
    load_val = lv;
    model_step(1'b1, lv);
    clk1;
    load = 1'b0;
    chk("load_count", count, bcd(cnt));
    chk("load_tc", tc, 0);
  endtask

  // one clk_div period: 8 cycles low then 8 high, update expected 2 edges after E
  task automatic do_tick(input bit ld, input logic [15:0] lv);
    clk_div = 1'b0;
    repeat (8) clk1;
    chk("low_hold", count, bcd(cnt));
    chk("low_tick", tick, 0);
    clk_div = 1'b1;
    clk1;
    chk("tick_e0", tick, 0);
    clk1;
    chk("tick_e1", tick, 1);
    chk("pre_upd", count, bcd(cnt));
    if (ld) begin
      load = 1'b1;
      load_val = lv;
    end
    model_step(ld, lv);
    clk1;
    load = 1'b0;
    chk("upd_count", count, bcd(cnt));
    chk("upd_tc", tc, etc);
    chk("tick_e2", tick, 0);
    clk1;
    chk("tc_one", tc, 0);
    repeat (4) clk1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", count, 0);
    chk("rst_tc", tc, 0);
    chk("rst_tick", tick, 0);
    rst = 1'b1;
    repeat (8) begin
      clk1;
      chk("rel_tick", tick, 0);
      chk("rel_count", count, 0);
      chk("rel_tc", tc, 0);
    end
    en = 1'b1;
    up = 1'b1;
    for (int k = 0; k < 12; k++) do_tick(1'b0, '0);
    chk("up12", count, 16'h0012);
    do_load(16'h9998);
    do_tick(1'b0, '0);
    chk("w9999", count, 16'h9999);
    do_tick(1'b0, '0);
    do_load(16'h0100);
    up = 1'b0;
    do_tick(1'b0, '0);
    chk("b0099", count, 16'h0099);
    do_load(16'h0000);
    do_tick(1'b0, '0);
    do_tick(1'b0, 16'h3A7F);
    do_tick(1'b1, 16'h3A7F);
    chk("san3979", count, 16'h3979);
    en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      up = 1'($urandom);
      do_tick(1'b0, '0);
    end
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 3) == 0) do_load($urandom_range(0, 1) ? 16'h9998 : 16'h0001);
      if ($urandom_range(0, 5) == 0) do_load(16'($urandom));
      en = ($urandom_range(0, 3) != 0);
      up = 1'($urandom);
      do_tick($urandom_range(0, 5) == 0, 16'($urandom));
    end
    do_load(16'h0042);
    en = 1'b1;
    clk1;
    #3 rst = 1'b0;
    #1;
    cnt = 0;
    chk("arst_count", count, 0);
    chk("arst_tc", tc, 0);
    clk1;
    rst = 1'b1;
    do_load(16'h9999);
    up = 1'b1;
    clk_div = 1'b0;
    repeat (8) clk1;
    clk_div = 1'b1;
    repeat (3) clk1;
    chk("pre_arst_tc", tc, 1);
    #2 rst = 1'b0;
    #1;
    chk("arst_tc_cancel", tc, 0);
    chk("arst_count2", count, 0);
    clk1;
    rst = 1'b1;
    repeat (6) begin
      clk1;
      chk("rel2_tick", tick, 0);
    end
    cnt = 0;
    do_tick(1'b0, '0);
    chk("after_rst", count, 16'h0001);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
